// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode fields, forwarding sources and the EX-side results.
// The master side drives decode and forwarding, the slave side is the ID/EX register.
interface id_ex_stage_if #(
    parameter int ALU_OP_W = 4
);
    logic                stall;
    logic                flush;
    logic                id_valid;
    logic [4:0]          id_rs;
    logic [4:0]          id_rt;
    logic [31:0]         id_r_data1;
    logic [31:0]         id_r_data2;
    logic [4:0]          id_rd;
    logic [31:0]         id_imm;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic                id_alu_src;
    logic                id_reg_w;
    logic                id_mem_read;
    logic                id_mem_write;
    logic                id_mem_to_reg;
    logic                exmem_reg_w;
    logic [4:0]          exmem_rd;
    logic [31:0]         exmem_result;
    logic                memwb_reg_w;
    logic [4:0]          memwb_rd;
    logic [31:0]         memwb_data;
    logic                hazard_stall;
    logic                ex_valid;
    logic [31:0]         ex_op_a;
    logic [31:0]         ex_op_b;
    logic [31:0]         ex_store_data;
    logic [4:0]          ex_rd;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic                ex_reg_w;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_mem_to_reg;

    modport master (
        output stall, flush, id_valid, id_rs, id_rt, id_r_data1, id_r_data2, id_rd,
               id_imm, id_alu_op, id_alu_src, id_reg_w, id_mem_read, id_mem_write,
               id_mem_to_reg, exmem_reg_w, exmem_rd, exmem_result,
               memwb_reg_w, memwb_rd, memwb_data,
        input  hazard_stall, ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_rd,
               ex_alu_op, ex_reg_w, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );

    modport slave (
        input  stall, flush, id_valid, id_rs, id_rt, id_r_data1, id_r_data2, id_rd,
               id_imm, id_alu_op, id_alu_src, id_reg_w, id_mem_read, id_mem_write,
               id_mem_to_reg, exmem_reg_w, exmem_rd, exmem_result,
               memwb_reg_w, memwb_rd, memwb_data,
        output hazard_stall, ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_rd,
               ex_alu_op, ex_reg_w, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass at capture, EX/MEM and MEM/WB
// operand forwarding, and load-use hazard detection.
module id_ex_stage #(
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int ALU_OP_W           = 4
) (
    input logic           clk,
    input logic           rst_n,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic                valid;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          rd;
        logic [31:0]         data_a;
        logic [31:0]         data_b;
        logic [31:0]         imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                reg_w;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
    } slot_t;

    slot_t       ex_q;
    slot_t       id_slot;
    logic        hazard;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    function automatic logic src_hit(input logic w_en, input logic [4:0] w_addr,
                                     input logic [4:0] src);
        return w_en && (w_addr == src) && ((ZERO_REG_HARDWIRED == 0) || (src != 5'd0));
    endfunction

    function automatic logic [31:0] forward_sel(input logic [4:0] src, input logic [31:0] data,
                                                input logic ex_w, input logic [4:0] ex_rd,
                                                input logic [31:0] ex_res, input logic wb_w,
                                                input logic [4:0] wb_rd, input logic [31:0] wb_data);
        if ((ZERO_REG_HARDWIRED != 0) && (src == 5'd0)) begin
            return 32'd0;
        end
        if (src_hit(ex_w, ex_rd, src)) begin
            return ex_res;
        end
        if (src_hit(wb_w, wb_rd, src)) begin
            return wb_data;
        end
        return data;
    endfunction

    // The write-back bypass covers a regfile write landing on the same edge as this capture.
    always_comb begin
        id_slot = '0;
        if (bus.id_valid) begin
            id_slot.valid      = 1'b1;
            id_slot.rs         = bus.id_rs;
            id_slot.rt         = bus.id_rt;
            id_slot.rd         = bus.id_rd;
            id_slot.data_a     = src_hit(bus.memwb_reg_w, bus.memwb_rd, bus.id_rs)
                                 ? bus.memwb_data : bus.id_r_data1;
            id_slot.data_b     = src_hit(bus.memwb_reg_w, bus.memwb_rd, bus.id_rt)
                                 ? bus.memwb_data : bus.id_r_data2;
            id_slot.imm        = bus.id_imm;
            id_slot.alu_op     = bus.id_alu_op;
            id_slot.alu_src    = bus.id_alu_src;
            id_slot.reg_w      = bus.id_reg_w;
            id_slot.mem_read   = bus.id_mem_read;
            id_slot.mem_write  = bus.id_mem_write;
            id_slot.mem_to_reg = bus.id_mem_to_reg;
        end
    end

    assign hazard = rst_n && !bus.flush && ex_q.valid && ex_q.mem_read && bus.id_valid &&
                    ((ex_q.rd == bus.id_rs) || (ex_q.rd == bus.id_rt)) && (ex_q.rd != 5'd0);

    // Flush outranks stall so a redirect kills the slot even while frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (bus.stall) begin
            ex_q <= ex_q;
        end else if (hazard) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_slot;
        end
    end

    always_comb begin
        fwd_a = forward_sel(ex_q.rs, ex_q.data_a, bus.exmem_reg_w, bus.exmem_rd, bus.exmem_result,
                            bus.memwb_reg_w, bus.memwb_rd, bus.memwb_data);
        fwd_b = forward_sel(ex_q.rt, ex_q.data_b, bus.exmem_reg_w, bus.exmem_rd, bus.exmem_result,
                            bus.memwb_reg_w, bus.memwb_rd, bus.memwb_data);
    end

    assign bus.hazard_stall  = hazard;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_op_a       = fwd_a;
    assign bus.ex_op_b       = ex_q.alu_src ? ex_q.imm : fwd_b;
    assign bus.ex_store_data = fwd_b;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_reg_w      = ex_q.reg_w;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against an instruction-level model
// of what the EX slot holds and which producer supplies each operand.
module tb_id_ex_stage;
    localparam int ALU_OP_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.ALU_OP_W(ALU_OP_W)) bus ();

    id_ex_stage #(.ZERO_REG_HARDWIRED(1), .ALU_OP_W(ALU_OP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          valid;
        int unsigned rs, rt, rd;
        logic [31:0] a, b, imm;
        int unsigned alu_op;
        bit          alu_src, reg_w, mem_read, mem_write, mem_to_reg;
    } instr_t;

    instr_t m;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Youngest in-flight writer of a register supplies its value; register 0 is always 0.
    function automatic logic [31:0] value_of(input int unsigned src, input logic [31:0] captured);
        if (src == 0) return 32'd0;
        if (bus.exmem_reg_w && int'(bus.exmem_rd) == src) return bus.exmem_result;
        if (bus.memwb_reg_w && int'(bus.memwb_rd) == src) return bus.memwb_data;
        return captured;
    endfunction

    function automatic bit exp_hazard();
        bit dep;
        dep = (m.rd == int'(bus.id_rs)) || (m.rd == int'(bus.id_rt));
        return rst_n && !bus.flush && m.valid && m.mem_read && bus.id_valid && dep && m.rd != 0;
    endfunction

    task automatic model_update();
        instr_t nxt;
        bit kill;
        kill = !rst_n || bus.flush || (!bus.stall && (exp_hazard() || !bus.id_valid));
        if (kill) begin
            m = '{default: '0};
        end else if (!bus.stall) begin
            nxt.valid      = 1'b1;
            nxt.rs         = bus.id_rs;
            nxt.rt         = bus.id_rt;
            nxt.rd         = bus.id_rd;
            nxt.a          = (bus.memwb_reg_w && bus.memwb_rd == bus.id_rs && bus.id_rs != 0)
                             ? bus.memwb_data : bus.id_r_data1;
            nxt.b          = (bus.memwb_reg_w && bus.memwb_rd == bus.id_rt && bus.id_rt != 0)
                             ? bus.memwb_data : bus.id_r_data2;
            nxt.imm        = bus.id_imm;
            nxt.alu_op     = bus.id_alu_op;
            nxt.alu_src    = bus.id_alu_src;
            nxt.reg_w      = bus.id_reg_w;
            nxt.mem_read   = bus.id_mem_read;
            nxt.mem_write  = bus.id_mem_write;
            nxt.mem_to_reg = bus.id_mem_to_reg;
            m = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag);
        logic [31:0] b_val;
        #1;
        b_val = value_of(m.rt, m.b);
        chk({tag, "_valid"},  32'(bus.ex_valid),      32'(m.valid));
        chk({tag, "_op_a"},   bus.ex_op_a,            value_of(m.rs, m.a));
        chk({tag, "_op_b"},   bus.ex_op_b,            m.alu_src ? m.imm : b_val);
        chk({tag, "_store"},  bus.ex_store_data,      b_val);
        chk({tag, "_rd"},     32'(bus.ex_rd),         m.rd);
        chk({tag, "_alu_op"}, 32'(bus.ex_alu_op),     m.alu_op);
        chk({tag, "_reg_w"},  32'(bus.ex_reg_w),      32'(m.reg_w));
        chk({tag, "_mrd"},    32'(bus.ex_mem_read),   32'(m.mem_read));
        chk({tag, "_mwr"},    32'(bus.ex_mem_write),  32'(m.mem_write));
        chk({tag, "_m2r"},    32'(bus.ex_mem_to_reg), 32'(m.mem_to_reg));
        chk({tag, "_hazard"}, 32'(bus.hazard_stall),  32'(exp_hazard()));
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.id_r_data1 = 0; bus.id_r_data2 = 0; bus.id_imm = 0; bus.id_alu_op = 0;
        bus.id_alu_src = 0; bus.id_reg_w = 0; bus.id_mem_read = 0;
        bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
        bus.exmem_reg_w = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_w = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
    endtask

    task automatic apply_stimulus();
        rst_n             = ($urandom_range(0, 49) != 0);
        bus.stall         = ($urandom_range(0, 7) == 0);
        bus.flush         = ($urandom_range(0, 9) == 0);
        bus.id_valid      = ($urandom_range(0, 3) != 0);
        bus.id_rs         = 5'($urandom_range(0, 7));
        bus.id_rt         = 5'($urandom_range(0, 7));
        bus.id_rd         = 5'($urandom_range(0, 7));
        bus.id_r_data1    = $urandom;
        bus.id_r_data2    = $urandom;
        bus.id_imm        = $urandom;
        bus.id_alu_op     = 4'($urandom);
        bus.id_alu_src    = 1'($urandom_range(0, 1));
        bus.id_reg_w      = 1'($urandom_range(0, 1));
        bus.id_mem_read   = 1'($urandom_range(0, 1));
        bus.id_mem_write  = 1'($urandom_range(0, 1));
        bus.id_mem_to_reg = 1'($urandom_range(0, 1));
        bus.exmem_reg_w   = 1'($urandom_range(0, 1));
        bus.exmem_rd      = 5'($urandom_range(0, 7));
        bus.exmem_result  = $urandom;
        bus.memwb_reg_w   = 1'($urandom_range(0, 1));
        bus.memwb_rd      = 5'($urandom_range(0, 7));
        bus.memwb_data    = $urandom;
    endtask

    initial begin
        m = '{default: '0};
        clear_inputs();
        rst_n = 0;
        bus.id_valid = 1; bus.id_reg_w = 1; bus.id_rs = 3; bus.id_r_data1 = 32'd7;
        tick();
        check_output("rst1");
        tick();
        check_output("rst2");
        chk("rst_hazard", 32'(bus.hazard_stall), 32'd0);
        chk("rst_valid", 32'(bus.ex_valid), 32'd0);

        rst_n = 1;
        tick();
        check_output("post_rst");
        chk("post_rst_op_a", bus.ex_op_a, 32'd7);

        // Forwarding priority and register-0 handling
        bus.id_rs = 5; bus.id_r_data1 = 32'd1;
        tick();
        bus.id_valid = 0;
        bus.exmem_reg_w = 1; bus.exmem_rd = 5; bus.exmem_result = 32'hAA;
        bus.memwb_reg_w = 1; bus.memwb_rd = 5; bus.memwb_data = 32'hBB;
        check_output("fwd_ex");
        chk("fwd_ex_op_a", bus.ex_op_a, 32'hAA);
        bus.exmem_reg_w = 0;
        check_output("fwd_wb");
        chk("fwd_wb_op_a", bus.ex_op_a, 32'hBB);
        bus.id_valid = 1; bus.id_rs = 0; bus.id_r_data1 = 32'h55; bus.memwb_reg_w = 0;
        tick();
        bus.id_valid = 0;
        bus.exmem_reg_w = 1; bus.exmem_rd = 0; bus.exmem_result = 32'hCC;
        bus.memwb_reg_w = 1; bus.memwb_rd = 0; bus.memwb_data = 32'hDD;
        check_output("zero");
        chk("zero_op_a", bus.ex_op_a, 32'd0);

        // Write-back landing on the capture edge
        clear_inputs();
        bus.id_valid = 1; bus.id_rt = 9; bus.id_r_data2 = 32'h11;
        bus.memwb_reg_w = 1; bus.memwb_rd = 9; bus.memwb_data = 32'h22;
        tick();
        bus.memwb_reg_w = 0; bus.id_valid = 0;
        check_output("wb_bypass");
        chk("wb_bypass_op_b", bus.ex_op_b, 32'h22);
        chk("wb_bypass_store", bus.ex_store_data, 32'h22);

        // Load-use pair
        bus.id_valid = 1; bus.id_rs = 1; bus.id_rt = 2; bus.id_rd = 4;
        bus.id_mem_read = 1; bus.id_reg_w = 1;
        tick();
        bus.id_rs = 4; bus.id_rd = 6; bus.id_mem_read = 0;
        check_output("lu_detect");
        chk("lu_hazard", 32'(bus.hazard_stall), 32'd1);
        tick();
        check_output("lu_bubble");
        chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu_bubble_hazard", 32'(bus.hazard_stall), 32'd0);
        tick();
        check_output("lu_dep");
        chk("lu_dep_rd", 32'(bus.ex_rd), 32'd6);

        // Freeze a store, then flush it while still frozen
        bus.id_rs = 7; bus.id_rd = 0; bus.id_reg_w = 0; bus.id_mem_write = 1;
        tick();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.id_r_data1 = $urandom; bus.id_rd = 5'($urandom_range(1, 7));
            check_output("stall");
            tick();
        end
        check_output("stall_end");
        chk("stall_mwr", 32'(bus.ex_mem_write), 32'd1);
        bus.flush = 1;
        tick();
        bus.flush = 0; bus.stall = 0;
        check_output("flush");
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_mwr", 32'(bus.ex_mem_write), 32'd0);

        // Immediate selected for op_b while store data still forwards
        clear_inputs();
        bus.id_valid = 1; bus.id_alu_src = 1; bus.id_imm = 32'hFFFF_FFFC;
        bus.id_rt = 10; bus.id_r_data2 = 32'h5;
        tick();
        bus.id_valid = 0;
        bus.exmem_reg_w = 1; bus.exmem_rd = 10; bus.exmem_result = 32'h30;
        check_output("imm");
        chk("imm_op_b", bus.ex_op_b, 32'hFFFF_FFFC);
        chk("imm_store", bus.ex_store_data, 32'h30);

        for (int i = 0; i < 400; i++) begin
            apply_stimulus();
            check_output("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the MIPS core, directly downstream of the 32x32 register file.
- Captures the two register-file read ports, immediate, destination and control from decode.
- Resolves RAW hazards with EX/MEM and MEM/WB forwarding plus a same-edge write-back bypass.
- Detects load-use hazards and drives operands into the ALU stage.

Parameters:
- ZERO_REG_HARDWIRED, 1, when 1 source/dest address 0 reads as 0 and is never forwarded or bypassed.
- ALU_OP_W, 4, width of the ALU operation code.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  downstream freeze; hold all EX state
- flush  in  1  kill the instruction entering EX (branch/jump redirect)
- id_valid  in  1  decode slot holds a real instruction
- id_rs, id_rt  in  5  source register addresses (same values driven to r_reg1/r_reg2)
- id_r_data1, id_r_data2  in  32  register-file read data
- id_rd  in  5  destination register address
- id_imm  in  32  sign/zero-extended immediate
- id_alu_op  in  ALU_OP_W  ALU operation
- id_alu_src, id_reg_w, id_mem_read, id_mem_write, id_mem_to_reg  in  1  decode control
- exmem_reg_w  in  1; exmem_rd  in  5; exmem_result  in  32  EX/MEM forwarding source
- memwb_reg_w  in  1; memwb_rd  in  5; memwb_data  in  32  MEM/WB source (same nets as regfile reg_w, w_reg_addr, w_data)
- hazard_stall  out  1  load-use stall request to PC and IF/ID
- ex_valid  out  1  EX slot valid
- ex_op_a, ex_op_b  out  32  forwarded ALU operands
- ex_store_data  out  32  forwarded rt value for stores
- ex_rd  out  5; ex_alu_op  out  ALU_OP_W
- ex_reg_w, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1

Behaviour:
- Registered state: valid, rs, rt, rd, data_a, data_b, imm, alu_op, all control bits.
- Per rising edge, first match wins:
  1. rst_n=0: everything cleared to 0.
  2. flush=1: bubble.
  3. stall=1: hold.
  4. hazard_stall=1: bubble.
  5. Otherwise: load from id_*.
- Flush beats stall: a flushed slot is killed even while frozen.
- Bubble: valid=0, all control bits 0, all data/address fields 0.
- Loading with id_valid=0 is also a bubble.
- Write-back bypass at load:
  - If memwb_reg_w=1 and memwb_rd==id_rs (and nonzero when ZERO_REG_HARDWIRED=1), data_a latches memwb_data, else id_r_data1.
  - Same rule for data_b with id_rt.
  - Covers the regfile write landing on the same edge.
- Operand forwarding, combinational from registered state, per operand (a uses rs/data_a, b uses rt/data_b):
  - EX/MEM hit (exmem_reg_w=1, exmem_rd==src, src!=0 if hardwired) takes exmem_result.
  - Else MEM/WB hit takes memwb_data.
  - Else the registered data is used.
  - EX/MEM has priority when both hit.
- With ZERO_REG_HARDWIRED=1, src==0 yields 0 regardless of data.
- ex_op_a = forwarded a. ex_store_data = forwarded b. ex_op_b = imm if alu_src=1, else forwarded b.
- hazard_stall is combinational:
  - Asserted when valid & mem_read (registered) & id_valid & (ex_rd==id_rs or ex_rd==id_rt) & ex_rd!=0.
  - Asserted for exactly one cycle per load-use pair; the bubble clears the condition.
  - Forced 0 while rst_n=0, and masked while flush=1.
- Latency: one cycle from id_* to ex_* registered fields; forwarded outputs follow sources in the same cycle.
- All outputs are 0 after reset, including hazard_stall. Reset mid-stall discards the held instruction.

Test Plan:
- Reset: rst_n=0 two cycles with id_valid=1, id_reg_w=1 -> all outputs 0; rst_n=1, id_rs=3, id_r_data1=7 -> next cycle ex_valid=1, ex_op_a=7.
- Forwarding: EX holds rs=5, data_a=1; exmem_rd=5, exmem_result=0xAA, memwb_rd=5, memwb_data=0xBB, both reg_w=1 -> ex_op_a=0xAA; drop exmem_reg_w -> 0xBB; rs=0 with exmem_rd=0 -> ex_op_a=0.
- WB bypass: id_rt=9, id_r_data2=0x11, memwb_reg_w=1, memwb_rd=9, memwb_data=0x22, id_alu_src=0 -> after edge, with no forwarding hits, ex_op_b=0x22, ex_store_data=0x22.
- Load-use: EX holds lw with rd=4; id_rs=4, id_valid=1 -> hazard_stall=1 that cycle; next cycle ex_valid=0, ex_reg_w=0, hazard_stall=0; following edge loads the dependent instruction.
- Stall/flush: stall=1 for 3 cycles -> EX outputs constant; stall=1 and flush=1 together -> next cycle ex_valid=0, ex_mem_write=0.
- Immediate select: id_alu_src=1, id_imm=0xFFFFFFFC, id_rt forwarded to 0x30 -> ex_op_b=0xFFFFFFFC, ex_store_data=0x30.
